// File: rtl/stopwatch_lap.sv
// Run/pause stopwatch with BCD mm:ss:cc output, lap capture FIFO (first-word-fall-through)
// and selectable wrap/saturate at 59:59.99.
module stopwatch_lap #(
   parameter int unsigned CLK_HZ    = 100000000,
   parameter int unsigned TICK_HZ   = 100,
   parameter int unsigned LAP_DEPTH = 4,
   parameter int unsigned ROLLOVER  = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           lap,
   output logic [7:0]                     time_cs,
   output logic [7:0]                     time_sec,
   output logic [7:0]                     time_min,
   output logic                           running,
   output logic                           ovf,
   output logic                           lap_valid,
   input  logic                           lap_ready,
   output logic [23:0]                    lap_data,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
   output logic                           lap_drop
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(LAP_DEPTH);
   localparam int unsigned CW  = $clog2(LAP_DEPTH + 1);
   localparam bit          SAT = (ROLLOVER == 0);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q;
   logic [23:0]   tq, tq_d;
   logic [5:0]    c;
   logic          tick, terminal, sat_hit, advance;

   assign tick     = (state_q == RUN) && (presc_q == PW'(DIV - 1));
   assign terminal = tick && (tq == 24'h595999);
   assign sat_hit  = SAT && terminal;
   assign advance  = tick && !sat_hit;

   function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] top,
                                          input logic cin);
      if (!cin)
         return {1'b0, d};
      if (d == top)
         return {1'b1, 4'd0};
      return {1'b0, d + 4'd1};
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (sat_hit) state_d = DONE;
                  else if (start) state_d = PAUSE;
         PAUSE:   if (start) state_d = RUN;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Whole carry chain resolves in one edge; c[5] is the wrap out of 59:59.99.
   always_comb begin
      c    = '0;
      tq_d = tq;
      {c[0], tq_d[3:0]}   = bcd_inc(tq[3:0],   4'd9, advance);
      {c[1], tq_d[7:4]}   = bcd_inc(tq[7:4],   4'd9, c[0]);
      {c[2], tq_d[11:8]}  = bcd_inc(tq[11:8],  4'd9, c[1]);
      {c[3], tq_d[15:12]} = bcd_inc(tq[15:12], 4'd5, c[2]);
      {c[4], tq_d[19:16]} = bcd_inc(tq[19:16], 4'd9, c[3]);
      {c[5], tq_d[23:20]} = bcd_inc(tq[23:20], 4'd5, c[4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         tq      <= '0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == RUN)
            presc_q <= tick ? '0 : presc_q + PW'(1);
         tq <= tq_d;
         if (c[5] || sat_hit)
            ovf <= 1'b1;
      end
   end

   assign running  = (state_q == RUN);
   assign time_cs  = tq[7:0];
   assign time_sec = tq[15:8];
   assign time_min = tq[23:16];

   logic [23:0]   mem [LAP_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_req, push, pop, full;

   assign lap_valid = (lap_count != '0);
   assign full      = (lap_count == CW'(LAP_DEPTH));
   assign pop       = lap_valid && lap_ready;
   assign push_req  = lap && (state_q != IDLE);
   // When full, a simultaneous pop frees the slot the write lands in (wr_ptr == rd_ptr).
   assign push      = push_req && (!full || pop);
   assign lap_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         lap_count <= '0;
         lap_drop  <= 1'b0;
         for (int unsigned i = 0; i < LAP_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= tq;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   lap_count <= lap_count + CW'(1);
            2'b01:   lap_count <= lap_count - CW'(1);
            default: lap_count <= lap_count;
         endcase
         if (push_req && !push)
            lap_drop <= 1'b1;
      end
   end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: a DIV=10 instance checked every cycle against a centisecond/queue
// model, plus DIV=2 wrap and saturate instances run through a full hour.
module tb_stopwatch_lap;

   localparam int unsigned DIV    = 10;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned FULL_T = 360000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, lap, lap_ready;
   logic [7:0]  time_cs, time_sec, time_min;
   logic        running, ovf, lap_valid, lap_drop;
   logic [23:0] lap_data;
   logic [2:0]  lap_count;

   stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4), .ROLLOVER(1)) dut (
      .clk(clk), .reset(reset), .start(start), .lap(lap),
      .time_cs(time_cs), .time_sec(time_sec), .time_min(time_min),
      .running(running), .ovf(ovf), .lap_valid(lap_valid), .lap_ready(lap_ready),
      .lap_data(lap_data), .lap_count(lap_count), .lap_drop(lap_drop));

   logic        r_reset, r_start, r_lap, r_ready;
   logic [7:0]  w_cs, w_sec, w_min, s_cs, s_sec, s_min;
   logic        w_running, w_ovf, w_valid, w_drop, s_running, s_ovf, s_valid, s_drop;
   logic [23:0] w_data, s_data;
   logic [2:0]  w_count, s_count;
   bit          long_done = 1'b0;

   stopwatch_lap #(.CLK_HZ(200), .TICK_HZ(100), .LAP_DEPTH(4), .ROLLOVER(1)) dut_wrap (
      .clk(clk), .reset(r_reset), .start(r_start), .lap(r_lap),
      .time_cs(w_cs), .time_sec(w_sec), .time_min(w_min),
      .running(w_running), .ovf(w_ovf), .lap_valid(w_valid), .lap_ready(r_ready),
      .lap_data(w_data), .lap_count(w_count), .lap_drop(w_drop));

   stopwatch_lap #(.CLK_HZ(200), .TICK_HZ(100), .LAP_DEPTH(4), .ROLLOVER(0)) dut_sat (
      .clk(clk), .reset(r_reset), .start(r_start), .lap(r_lap),
      .time_cs(s_cs), .time_sec(s_sec), .time_min(s_min),
      .running(s_running), .ovf(s_ovf), .lap_valid(s_valid), .lap_ready(r_ready),
      .lap_data(s_data), .lap_count(s_count), .lap_drop(s_drop));

   int unsigned n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] bcd2(input int unsigned v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [23:0] disp(input int unsigned t);
      return {bcd2(t / 6000), bcd2((t / 100) % 60), bcd2(t % 100)};
   endfunction

   // Model: elapsed centiseconds, edges into the current tick, and the lap queue.
   bit          m_started, m_run, m_ovf, m_drop;
   int unsigned m_ticks, m_phase;
   logic [23:0] m_q[$];

   task automatic model_step(input bit rs, input bit st, input bit lp, input bit rd);
      logic [23:0] now;
      if (rs) begin
         m_started = 0; m_run = 0; m_ovf = 0; m_drop = 0;
         m_ticks = 0; m_phase = 0;
         m_q.delete();
         return;
      end
      now = disp(m_ticks);
      if (rd && m_q.size() != 0)
         void'(m_q.pop_front());
      if (lp && m_started) begin
         if (m_q.size() < DEPTH) m_q.push_back(now);
         else m_drop = 1;
      end
      if (m_run) begin
         m_phase++;
         if (m_phase == DIV) begin
            m_phase = 0;
            m_ticks++;
            if (m_ticks == FULL_T) begin
               m_ticks = 0;
               m_ovf = 1;
            end
         end
      end
      if (st) begin
         m_started = 1;
         m_run = !m_run;
      end
   endtask

   task automatic compare_all();
      logic [23:0] t;
      t = disp(m_ticks);
      check("time_cs", time_cs, t[7:0]);
      check("time_sec", time_sec, t[15:8]);
      check("time_min", time_min, t[23:16]);
      check("running", running, m_run);
      check("ovf", ovf, m_ovf);
      check("lap_count", lap_count, m_q.size());
      check("lap_valid", lap_valid, m_q.size() != 0);
      check("lap_drop", lap_drop, m_drop);
      if (m_q.size() != 0)
         check("lap_data", lap_data, m_q[0]);
   endtask

   task automatic cycle(input bit rs, input bit st, input bit lp, input bit rd);
      reset = rs; start = st; lap = lp; lap_ready = rd;
      @(posedge clk);
      model_step(rs, st, lp, rd);
      #1;
      compare_all();
   endtask

   task automatic run_n(input int unsigned n, input bit rd);
      for (int unsigned i = 0; i < n; i++)
         cycle(0, 0, 0, rd);
   endtask

   task automatic lap_at(input int unsigned target);
      int unsigned guard;
      guard = 0;
      while (m_ticks != target && guard < 2000) begin
         cycle(0, 0, 0, 0);
         guard++;
      end
      check("lap_at_reached", m_ticks, target);
      cycle(0, 0, 1, 0);
   endtask

   initial begin
      logic [23:0] tail;
      logic [23:0] exp_laps [4];
      exp_laps[0] = 24'h000003; exp_laps[1] = 24'h000007;
      exp_laps[2] = 24'h000012; exp_laps[3] = 24'h000020;

      reset = 1; start = 0; lap = 0; lap_ready = 0;
      // basic count
      cycle(1, 0, 0, 0);
      check("reset_running", running, 0);
      cycle(0, 1, 0, 0);
      check("start_running", running, 1);
      run_n(9, 0);
      check("cs_before_first_tick", time_cs, 8'h00);
      run_n(1, 0);
      check("first_tick_cs", time_cs, 8'h01);
      run_n(990, 0);
      check("one_sec_sec", time_sec, 8'h01);
      check("one_sec_cs", time_cs, 8'h00);

      // pause/resume keeps the partial tick
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      run_n(255, 0);
      cycle(0, 1, 0, 0);
      run_n(500, 0);
      check("paused_cs", time_cs, 8'h25);
      check("paused_running", running, 0);
      cycle(0, 1, 0, 0);
      run_n(3, 0);
      check("resume_cs_hold", time_cs, 8'h25);
      run_n(1, 0);
      check("resume_cs_tick", time_cs, 8'h26);

      // lap FIFO overflow then drain
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      lap_at(3); lap_at(7); lap_at(12); lap_at(20); lap_at(31);
      check("full_count", lap_count, 4);
      check("full_drop", lap_drop, 1);
      for (int k = 0; k < 4; k++) begin
         check("drain_data", lap_data, exp_laps[k]);
         cycle(0, 0, 0, 1);
      end
      check("drained_valid", lap_valid, 0);

      // full FIFO with push and pop on one edge
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         run_n(7, 0);
         cycle(0, 0, 1, 0);
      end
      run_n(5, 0);
      tail = disp(m_ticks);
      cycle(0, 0, 1, 1);
      check("simul_count", lap_count, 4);
      check("simul_drop", lap_drop, 0);
      run_n(3, 1);
      check("simul_tail", lap_data, tail);

      // reset interactions
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      run_n(40, 0);
      cycle(0, 0, 1, 0);
      run_n(40, 0);
      cycle(0, 0, 1, 0);
      check("pre_reset_count", lap_count, 2);
      cycle(1, 0, 0, 0);
      check("rst_time", {time_min, time_sec, time_cs}, 24'h0);
      check("rst_count", lap_count, 0);
      check("rst_data", lap_data, 24'h0);
      check("rst_valid", lap_valid, 0);
      check("rst_running", running, 0);
      cycle(1, 1, 0, 0);
      check("rst_start_running", running, 0);
      cycle(0, 0, 1, 0);
      check("idle_lap_count", lap_count, 0);

      // randomized traffic
      cycle(1, 0, 0, 0);
      for (int unsigned i = 0; i < 20000; i++)
         cycle(($urandom % 700) == 0, ($urandom % 150) == 0,
               ($urandom % 40) == 0, ($urandom % 4) == 0);

      wait (long_done);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      int unsigned t;
      r_reset = 1; r_start = 0; r_lap = 0; r_ready = 0;
      @(posedge clk); #1;
      check("long_rst_wrap", {w_min, w_sec, w_cs}, 24'h0);
      check("long_rst_sat", {s_min, s_sec, s_cs}, 24'h0);
      r_reset = 0; r_start = 1;
      @(posedge clk); #1;
      r_start = 0;
      for (int unsigned n = 1; n <= 720000; n++) begin
         @(posedge clk); #1;
         if ((n % 1000) == 0 || n >= 719996) begin
            t = n / 2;
            check("wrap_time", {w_min, w_sec, w_cs}, disp(t % FULL_T));
            check("wrap_ovf", w_ovf, t >= FULL_T);
            check("wrap_running", w_running, 1);
            check("sat_time", {s_min, s_sec, s_cs}, disp(t >= FULL_T ? FULL_T - 1 : t));
            check("sat_ovf", s_ovf, t >= FULL_T);
            check("sat_running", s_running, t < FULL_T);
         end
      end
      r_start = 1;
      @(posedge clk); #1;
      r_start = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
      end
      check("done_start_ignored", s_running, 0);
      check("done_time", {s_min, s_sec, s_cs}, 24'h595999);
      check("wrap_paused", w_running, 0);
      r_lap = 1;
      @(posedge clk); #1;
      r_lap = 0;
      check("done_lap_count", s_count, 1);
      check("done_lap_data", s_data, 24'h595999);
      check("wrap_pause_lap", w_data, 24'h000000);
      check("wrap_ovf_sticky", w_ovf, 1);
      long_done = 1'b1;
   end

endmodule
